// File: rtl/cla_mp_pkg.sv
// Shared types and constants for the multi-precision CLA add sequencer.
package cla_mp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_WORDS = 4;

  function automatic int idx_width(input int words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/CLA_12bit.sv
// Carry-lookahead adder slice: sum, carry-out and group propagate/generate.
module CLA_12bit #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_p,
  output logic             o_g
);

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH:0]   w_c;
  logic             w_gg;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Carries expand to lookahead terms g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    w_c    = '0;
    w_gg   = 1'b0;
    w_c[0] = i_cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      w_gg     = w_g[i] | (w_p[i] & w_gg);
    end
  end

  assign o_s    = w_p ^ w_c[WIDTH-1:0];
  assign o_cout = w_c[WIDTH];
  assign o_p    = &w_p;
  assign o_g    = w_gg;

endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision adder: streams WORDS chunks LSB-first through one CLA slice.
// Optional subtract mode (op_sub port) is enabled by defining CLA_MP_SUB_EN.
module cla_mp_add_seq
  import cla_mp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a_in,
  input  logic [WIDTH*WORDS-1:0] b_in,
  input  logic                   cin,
`ifdef CLA_MP_SUB_EN
  input  logic                   op_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum_out,
  output logic                   cout_out,
  output logic                   busy
);

  localparam int TW = WIDTH * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_e          r_state;
  state_e          w_next;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_a;
  logic [TW-1:0]   r_b;
  logic [TW-1:0]   r_sum;
  logic            r_carry;
  logic            r_cout;
  logic            w_accept;
  logic            w_last;
  logic            w_cin0;
  logic [31:0]     w_base;
  logic [WIDTH-1:0] w_a_chunk;
  logic [WIDTH-1:0] w_b_chunk;
  logic [WIDTH-1:0] w_s;
  logic            w_cout;
  logic            w_grp_p_unused;
  logic            w_grp_g_unused;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_base   = 32'(r_idx) * 32'(WIDTH);
  assign w_a_chunk = r_a[w_base +: WIDTH];

`ifdef CLA_MP_SUB_EN
  logic r_sub;
  // A-B as A + ~B + 1: invert B chunks and force the initial carry.
  assign w_b_chunk = r_b[w_base +: WIDTH] ^ {WIDTH{r_sub}};
  assign w_cin0    = op_sub ? 1'b1 : cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_sub <= 1'b0;
    else if (w_accept) r_sub <= op_sub;
  end
`else
  assign w_b_chunk = r_b[w_base +: WIDTH];
  assign w_cin0    = cin;
`endif

  CLA_12bit #(.WIDTH(WIDTH)) u_cla (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout),
    .o_p    (w_grp_p_unused),
    .o_g    (w_grp_g_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a_in;
      r_b     <= b_in;
      r_carry <= w_cin0;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      r_sum[w_base +: WIDTH] <= w_s;
      r_carry                <= w_cout;
      // idx parks at the last chunk rather than wrapping.
      if (w_last) r_cout <= w_cout;
      else        r_idx  <= r_idx + 1'b1;
    end
  end

  assign sum_out  = r_sum;
  assign cout_out = r_cout;

endmodule
